// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction prefetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  // One queued fetch result: the address it came from and the word fetched.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous ring-buffer FIFO with flush and occupancy count.
// The head entry is read combinationally; flush has priority over push/pop.
module fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Ignore pops of an empty buffer and pushes that would overflow it.
  always_comb begin
    pop_ok  = pop & (count != '0);
    push_ok = push & ((count != CW'(DEPTH)) | pop_ok);
  end

  assign head_data = mem[rd_ptr];

  // Pointer, count and storage update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage: fetches sequential words over a req/ack
// memory handshake, buffers {pc, instr} pairs and hands them to decode.
// A redirect flushes the buffer and restarts fetch at the new PC.
module prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_next_seq;
  logic [ADDR_W-1:0] redirect_target;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop_fire;
  logic              has_space;
  logic              room_after_push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [ENTRY_W-1:0] head_data;

  // Queue control and free-space accounting.
  // In REQ the in-flight fetch already owns a slot, so the only question is
  // whether another slot remains once its data lands (net of a same-cycle pop).
  always_comb begin
    pop_fire        = instr_valid & instr_ready & ~redirect;
    push            = (state == REQ) & mem_ack & ~redirect;
    has_space       = count < CW'(DEPTH);
    room_after_push = (count - CW'(pop_fire)) < CW'(DEPTH - 1);
    fpc_next_seq    = fpc + ADDR_W'(4);
    redirect_target = word_align(redirect_pc);
    push_entry.pc    = fpc;
    push_entry.instr = mem_rdata;
  end

  fifo_sync #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop_fire),
    .flush     (redirect),
    .head_data (head_data),
    .count     (count)
  );

  assign head_entry  = fetch_entry_t'(head_data);
  assign instr_valid = (count != '0);
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  // Fetch FSM with registered request outputs and the fetch PC.
  // A redirect while a request is outstanding cannot retract it, so DROP
  // keeps the old address on the bus until the stale ack arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fpc <= redirect_target;
          end else if (has_space) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fpc;
          end
        end
        REQ: begin
          if (redirect) begin
            fpc <= redirect_target;
            if (mem_ack) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (mem_ack) begin
            fpc <= fpc_next_seq;
            if (room_after_push) begin
              mem_addr <= fpc_next_seq;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            fpc <= redirect_target;
          end
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a latency-programmable memory
// model and a scoreboard of expected PCs in delivery order.
module tb_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp_pc;
  int          lat;
  int          wait_cnt;
  bit          poisoned;
  bit          prev_pending;
  logic [31:0] prev_addr;
  logic [31:0] last_acc;
  logic [31:0] last_pop;
  int          n_acc = 0;
  int          n_pop = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle, entered just after a falling edge with inputs set.
  task automatic cycle();
    logic [31:0] e;
    if (prev_pending) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_stable", mem_addr, prev_addr);
    end
    chk("valid_vs_model", 32'(instr_valid), 32'(q.size() != 0));
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = imem(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    prev_pending = mem_req && !mem_ack;
    prev_addr    = mem_addr;
    if (!redirect && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        chk("pop_model_empty", 32'(instr_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_instr", instr, imem(e));
        n_pop++;
        last_pop = instr_pc;
      end
    end
    if (mem_ack) begin
      if (redirect || poisoned) begin
        poisoned = 1'b0;
      end else begin
        chk("fetch_addr", mem_addr, exp_pc);
        q.push_back(exp_pc);
        if (q.size() > DEPTH) chk("overfetch", 32'(q.size()), 32'(DEPTH));
        exp_pc   = exp_pc + 32'd4;
        last_acc = mem_addr;
        n_acc++;
      end
    end
    if (redirect) begin
      if (mem_req && !mem_ack) poisoned = 1'b1;
      q.delete();
      exp_pc = redirect_pc & ~32'h3;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    mem_ack      = 1'b0;
    redirect     = 1'b0;
    instr_ready  = 1'b0;
    q.delete();
    exp_pc       = 32'h0;
    poisoned     = 1'b0;
    prev_pending = 1'b0;
    wait_cnt     = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int p0;
    int n;
    reset       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    lat         = 0;
    wait_cnt    = 0;
    exp_pc      = 32'h0;
    poisoned    = 1'b0;
    prev_pending = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // 1: streaming, one instruction per cycle
    reset       = 1'b1;
    instr_ready = 1'b1;
    repeat (5) cycle();
    p0 = n_pop;
    repeat (10) cycle();
    chk("t1_rate", 32'(n_pop - p0), 32'd10);

    // 2: consumer stalled fills the queue, one pop triggers one refetch
    do_reset();
    a0 = n_acc;
    repeat (12) cycle();
    chk("t2_acks", 32'(n_acc - a0), 32'd4);
    chk("t2_req_low", 32'(mem_req), 32'd0);
    chk("t2_count", 32'(dut.count), 32'd4);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    repeat (6) cycle();
    chk("t2_refill_acks", 32'(n_acc - a0), 32'd5);
    chk("t2_refill_addr", last_acc, 32'h10);
    chk("t2_req_low_again", 32'(mem_req), 32'd0);

    // 3: redirect while a slow request is outstanding
    do_reset();
    a0 = n_acc;
    n  = 0;
    while ((n_acc - a0) < 2 && n < 20) begin cycle(); n++; end
    chk("t3_warm", 32'(n_acc - a0), 32'd2);
    lat = 3;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    chk("t3_addr_held", mem_addr, 32'h8);
    chk("t3_req_held", 32'(mem_req), 32'd1);
    chk("t3_valid_flushed", 32'(instr_valid), 32'd0);
    n = 0;
    while ((n_acc - a0) < 3 && n < 30) begin cycle(); n++; end
    chk("t3_next_ack", 32'(n_acc - a0), 32'd3);
    chk("t3_next_addr", last_acc, 32'h100);

    // 4: redirect coinciding with the ack at 0x4
    do_reset();
    lat = 0;
    a0  = n_acc;
    n   = 0;
    while ((n_acc - a0) < 1 && n < 20) begin cycle(); n++; end
    chk("t4_warm", 32'(n_acc - a0), 32'd1);
    chk("t4_addr4", mem_addr, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    chk("t4_req_dropped", 32'(mem_req), 32'd0);
    chk("t4_empty", 32'(instr_valid), 32'd0);
    cycle();
    chk("t4_req_new", 32'(mem_req), 32'd1);
    chk("t4_addr_new", mem_addr, 32'h100);

    // 5: unaligned redirect target plus a same-cycle pop
    instr_ready = 1'b1;
    repeat (6) cycle();
    chk("t5_valid_before", 32'(instr_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    p0 = n_pop;
    cycle();
    redirect = 1'b0;
    chk("t5_valid_cleared", 32'(instr_valid), 32'd0);
    n = 0;
    while (n_pop == p0 && n < 20) begin cycle(); n++; end
    chk("t5_popped", 32'(n_pop - p0), 32'd1);
    chk("t5_first_pc", last_pop, 32'h100);
    repeat (4) cycle();

    // 6: asynchronous reset in the middle of a request
    lat = 5;
    n   = 0;
    while (!mem_req && n < 20) begin cycle(); n++; end
    chk("t6_req_up", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req", 32'(mem_req), 32'd0);
    chk("t6_async_addr", mem_addr, 32'h0);
    do_reset();
    lat = 0;
    instr_ready = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin cycle(); n++; end
    chk("t6_first_addr", mem_addr, 32'h0);
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
